// File: rtl/bsser.sv
// Parallel-to-bit-serial transmitter: W-bit words in over valid/ready, emitted LSB-first
// on q_o with osync_o marking bit 0. A one-word holding register lets words stream
// back to back.
// Optional feature macro: BSSER_UNDERRUN_EN adds a sticky underrun_o flag.
module bsser #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] din_i,
    input  logic         din_valid_i,
    output logic         din_ready_o,
    output logic         q_o,
    output logic         osync_o,
    output logic         active_o
`ifdef BSSER_UNDERRUN_EN
    ,
    output logic         underrun_o
`endif
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CntLast = CW'(W - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          hold_full_q, hold_full_d;

    logic accept;
    logic load_pt;

`ifdef BSSER_UNDERRUN_EN
    logic underrun_q, underrun_d;
`endif

    assign accept  = din_valid_i & ~hold_full_q;
    assign load_pt = (state_q == StIdle) | (cnt_q == CntLast);

    // Next-state: reload the shifter at word boundaries, otherwise shift and park
    // any newly accepted word in the holding register.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`ifdef BSSER_UNDERRUN_EN
        underrun_d  = underrun_q;
`endif
        if (load_pt) begin
            if (hold_full_q) begin
                sh_d        = hold_q;
                hold_full_d = 1'b0;
                cnt_d       = '0;
                state_d     = StShift;
            end else if (accept) begin
                // Word arriving exactly at the boundary bypasses hold.
                sh_d    = din_i;
                cnt_d   = '0;
                state_d = StShift;
            end else begin
                sh_d    = '0;
                cnt_d   = '0;
                state_d = StIdle;
`ifdef BSSER_UNDERRUN_EN
                // Only a word ending with nothing behind it counts as a gap.
                if (state_q == StShift) begin
                    underrun_d = 1'b1;
                end
`endif
            end
        end else begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (accept) begin
                hold_d      = din_i;
                hold_full_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`ifdef BSSER_UNDERRUN_EN
            underrun_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`ifdef BSSER_UNDERRUN_EN
            underrun_q  <= underrun_d;
`endif
        end
    end

    // Outputs decoded from registers only.
    always_comb begin
        active_o    = (state_q == StShift);
        q_o         = active_o & sh_q[0];
        osync_o     = active_o & (cnt_q == '0);
        din_ready_o = ~hold_full_q;
`ifdef BSSER_UNDERRUN_EN
        underrun_o  = underrun_q;
`endif
    end

endmodule
